imem_loader: RTL and testbench

Boot-time instruction-memory loader for the pipeline CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them through a write port into instruction memory. It holds the CPU in reset until the whole image is in memory, then releases it. It is the hardware writer for the instruction memory that the CPU fetch stage reads, and it replaces direct bench pokes of the memory array.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction-memory loader. Receives a byte stream
//            (16-bit big-endian word count, then big-endian 32-bit words),
//            writes each word into instruction memory and holds the CPU in
//            reset until the whole image has been written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Memory depth widened to 17 bits so that 2^16 is representable.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t            state;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_sr;     // first three bytes of the word in flight

    logic              accept;
    logic [15:0]       hdr_count;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    // Full word count as it becomes known on the second header byte.
    assign hdr_count = {count[15:8], in_data};
    // Compared in 17 bits so a full-depth image never overflows the sum.
    assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, count});

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_HDR_HI;
            count     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            in_ready  <= 1'b1;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_reset <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_HDR_HI: begin
                    if (accept) begin
                        count <= {in_data, 8'h00};
                        state <= S_HDR_LO;
                    end
                end

                S_HDR_LO: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            cpu_reset <= 1'b1;
                        end else if ({1'b0, hdr_count} > DEPTH) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state    <= S_DATA;
                            word_idx <= '0;
                            byte_cnt <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        word_sr  <= {word_sr[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte: present the word for one write cycle.
                            state    <= S_WRITE;
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= word_idx;
                            im_wdata <= {word_sr, in_data};
                        end
                    end
                end

                S_WRITE: begin
                    im_we <= 1'b0;
                    if (last_word) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                    end else begin
                        state    <= S_DATA;
                        word_idx <= word_idx + 1'b1;
                        byte_cnt <= '0;
                        in_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    in_ready <= 1'b0;
                end

                S_ERR: begin
                    in_ready <= 1'b0;
                end

                default: begin
                    state    <= S_ERR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader: cycle-exact vector table
//            for a two-word image plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    // Writes observed on the memory port, and stray in_ready drops.
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          viol = 0;

    imem_loader #(.ADDR_W(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Record each write pulse mid-cycle and flag in_ready dropping outside
    // a write cycle or a terminal state.
    always @(negedge clock) begin
        if (reset && im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
        if (reset && !in_ready && !im_we && !done && !error)
            viol = viol + 1;
    end

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        dn;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst im_we",     {31'd0, im_we},     32'd0);
        chk("rst im_addr",   {22'd0, im_addr},   32'd0);
        chk("rst im_wdata",  im_wdata,           32'd0);
        chk("rst cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("rst done",      {31'd0, done},      32'd0);
        chk("rst error",     {31'd0, error},     32'd0);
    endtask

    // Assert reset mid-cycle, check reset values, release just after an edge.
    task automatic do_reset();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b1;
    endtask

    // Offer one byte (after an optional idle gap) and wait until it transfers.
    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        logic rdy;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send timeout: byte 0x%02h never accepted", b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [7:0]  img[10];
        int          base;
        int          vbase;
        int          bad;
        logic [31:0] w;

        img = '{8'h00, 8'h02, 8'hAC, 8'h02, 8'h00, 8'h00, 8'h00, 8'h43, 8'h08, 8'h20};

        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 8'hAC, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 8'h02, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 10'h0, 32'hAC020000, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};  // held during WRITE
        vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 8'h43, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 8'h08, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 8'h20, 1'b0, 1'b1, 10'h1, 32'h00430820, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clock);
        #1;

        // ---- Two-word image, cycle-exact, valid held high ----
        do_reset();
        base = wr_addr.size();
        for (int i = 0; i < 13; i++) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d im_we", i),     {31'd0, im_we},     {31'd0, vecs[i].we});
            chk($sformatf("v%0d done", i),      {31'd0, done},      {31'd0, vecs[i].dn});
            chk($sformatf("v%0d cpu_reset", i), {31'd0, cpu_reset}, {31'd0, vecs[i].dn});
            if (vecs[i].we) begin
                chk($sformatf("v%0d im_addr", i),  {22'd0, im_addr}, {22'd0, vecs[i].addr});
                chk($sformatf("v%0d im_wdata", i), im_wdata,         vecs[i].wdata);
            end
        end
        chk("two-word error", {31'd0, error}, 32'd0);
        chk("two-word writes", wr_addr.size() - base, 32'd2);

        // ---- Zero count ----
        do_reset();
        base = wr_addr.size();
        send(8'h00, 0);
        send(8'h00, 0);
        chk("zero done",      {31'd0, done},      32'd1);
        chk("zero cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("zero in_ready",  {31'd0, in_ready},  32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle(0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("zero in_ready stays", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("zero writes", wr_addr.size() - base, 32'd0);

        // ---- Overflow: N = 1025 with 1024-word memory ----
        do_reset();
        base = wr_addr.size();
        send(8'h04, 0);
        send(8'h01, 0);
        idle(3);
        chk("ovf error",     {31'd0, error},     32'd1);
        chk("ovf done",      {31'd0, done},      32'd0);
        chk("ovf cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("ovf in_ready",  {31'd0, in_ready},  32'd0);
        chk("ovf writes",    wr_addr.size() - base, 32'd0);

        // ---- Two-word image with random valid gaps ----
        do_reset();
        base  = wr_addr.size();
        vbase = viol;
        for (int i = 0; i < 10; i++)
            send(img[i], int'($urandom_range(0, 3)));
        idle(2);
        chk("gap writes", wr_addr.size() - base, 32'd2);
        if (wr_addr.size() - base == 2) begin
            chk("gap addr0",  {22'd0, wr_addr[base]},   32'd0);
            chk("gap data0",  wr_data[base],            32'hAC020000);
            chk("gap addr1",  {22'd0, wr_addr[base+1]}, 32'd1);
            chk("gap data1",  wr_data[base+1],          32'h00430820);
        end
        chk("gap done",         {31'd0, done}, 32'd1);
        chk("gap ready drops",  viol - vbase,  32'd0);

        // ---- Reset mid-load, then a one-word image ----
        do_reset();
        for (int i = 0; i < 6; i++)
            send(img[i], 0);
        do_reset();
        base = wr_addr.size();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h27, 0);
        send(8'h00, 0);
        send(8'h08, 0);
        idle(2);
        chk("mid writes", wr_addr.size() - base, 32'd1);
        if (wr_addr.size() - base == 1) begin
            chk("mid addr", {22'd0, wr_addr[base]}, 32'd0);
            chk("mid data", wr_data[base],          32'h12270008);
        end
        chk("mid done",      {31'd0, done},      32'd1);
        chk("mid cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // ---- Full-depth image: 1024 words ----
        do_reset();
        base = wr_addr.size();
        send(8'h04, 0);
        send(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'hA5000000 | (32'(i) * 32'h00010001);
            send(w[31:24], 0);
            send(w[23:16], 0);
            send(w[15:8], 0);
            send(w[7:0], 0);
        end
        idle(2);
        chk("full writes", wr_addr.size() - base, 32'd1024);
        bad = 0;
        if (wr_addr.size() - base == 1024) begin
            for (int i = 0; i < 1024; i++) begin
                w = 32'hA5000000 | (32'(i) * 32'h00010001);
                if (wr_addr[base+i] !== 10'(i) || wr_data[base+i] !== w)
                    bad++;
            end
            chk("full last addr", {22'd0, wr_addr[base+1023]}, 32'h3FF);
        end
        chk("full bad words", bad, 32'd0);
        chk("full done",  {31'd0, done},  32'd1);
        chk("full error", {31'd0, error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
